// File: rtl/vyd_wbm_kopru.sv
// VYD request port to Wishbone B4 classic master bridge with N slaves.
// Address-window decode, byte selects, slave error, decode-miss error and a bus timeout.
module vyd_wbm_kopru #(
    parameter int ADRES_GENISLIGI    = 32,
    parameter int SOZCUK_GENISLIGI   = 32,
    parameter int IC_ADRES_GENISLIGI = 16,
    parameter int SLAVE_SAYISI       = 2,
    parameter logic [ADRES_GENISLIGI-1:0] SLAVE_BASLANGIC [SLAVE_SAYISI] = '{32'h1000_0000, 32'h2000_0000},
    parameter logic [ADRES_GENISLIGI-1:0] SLAVE_BITIS     [SLAVE_SAYISI] = '{32'h1000_FFFF, 32'h2000_FFFF},
    parameter int ZAMAN_ASIMI        = 255
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic [ADRES_GENISLIGI-1:0]             adres_i,
    input  logic [SOZCUK_GENISLIGI-1:0]            veri_i,
    input  logic [SOZCUK_GENISLIGI/8-1:0]          sec_i,
    input  logic                                   yaz_i,
    input  logic                                   istek_i,
    output logic                                   hazir_o,
    output logic [SOZCUK_GENISLIGI-1:0]            veri_o,
    output logic                                   hata_o,
    output logic [IC_ADRES_GENISLIGI-1:0]          wbs_adr_o,
    output logic [SOZCUK_GENISLIGI-1:0]            wbs_dat_o,
    output logic [SOZCUK_GENISLIGI/8-1:0]          wbs_sel_o,
    output logic [SLAVE_SAYISI-1:0]                wbs_we_o,
    output logic [SLAVE_SAYISI-1:0]                wbs_stb_o,
    output logic [SLAVE_SAYISI-1:0]                wbs_cyc_o,
    input  logic [SLAVE_SAYISI*SOZCUK_GENISLIGI-1:0] wbs_dat_i,
    input  logic [SLAVE_SAYISI-1:0]                wbs_ack_i,
    input  logic [SLAVE_SAYISI-1:0]                wbs_err_i
);
    localparam int SW = SOZCUK_GENISLIGI / 8;
    localparam int IW = (SLAVE_SAYISI > 1) ? $clog2(SLAVE_SAYISI) : 1;
    localparam int CW = (ZAMAN_ASIMI == 0) ? 1 : $clog2(ZAMAN_ASIMI + 1);
    localparam logic [CW-1:0] ZA_C    = CW'(ZAMAN_ASIMI);
    localparam logic [CW-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {BOSTA, ACK_BEKLE, YANIT} durum_t;

    durum_t                        r_durum, w_durum_next;
    logic [IC_ADRES_GENISLIGI-1:0] r_adr;
    logic [SOZCUK_GENISLIGI-1:0]   r_dat;
    logic [SW-1:0]                 r_sel;
    logic                          r_yaz;
    logic [IW-1:0]                 r_idx;
    logic [CW-1:0]                 r_cnt;
    logic [SOZCUK_GENISLIGI-1:0]   r_veri;
    logic                          r_hata;

    logic [SLAVE_SAYISI-1:0]       w_hit;
    logic [SLAVE_SAYISI-1:0]       w_aktif;
    logic                          w_any;
    logic [IW-1:0]                 w_idx;
    logic                          w_ack;
    logic                          w_err;
    logic [SOZCUK_GENISLIGI-1:0]   w_rdat;
    logic [CW-1:0]                 w_cnt_inc;
    logic                          w_timeout;

    genvar gi;
    generate
        for (gi = 0; gi < SLAVE_SAYISI; gi++) begin : g_slave
            assign w_hit[gi]   = (adres_i >= SLAVE_BASLANGIC[gi]) && (adres_i <= SLAVE_BITIS[gi]);
            assign w_aktif[gi] = (r_durum == ACK_BEKLE) && (r_idx == IW'(gi));
        end
    endgenerate

    // Scan downward so the lowest-numbered overlapping window takes the request.
    always_comb begin
        w_idx = '0;
        w_any = |w_hit;
        for (int i = SLAVE_SAYISI - 1; i >= 0; i--) begin
            if (w_hit[i]) w_idx = IW'(i);
        end
    end

    assign w_ack     = wbs_ack_i[r_idx];
    assign w_err     = wbs_err_i[r_idx];
    assign w_rdat    = wbs_dat_i[r_idx*SOZCUK_GENISLIGI +: SOZCUK_GENISLIGI];
    assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
    assign w_timeout = (ZAMAN_ASIMI != 0) && (w_cnt_inc == ZA_C);

    always_comb begin
        w_durum_next = r_durum;
        case (r_durum)
            BOSTA:     if (istek_i) w_durum_next = w_any ? ACK_BEKLE : YANIT;
            ACK_BEKLE: if (w_err || w_ack || w_timeout) w_durum_next = YANIT;
            YANIT:     w_durum_next = BOSTA;
            default:   w_durum_next = BOSTA;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) r_durum <= BOSTA;
        else       r_durum <= w_durum_next;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_adr  <= '0;
            r_dat  <= '0;
            r_sel  <= '0;
            r_yaz  <= 1'b0;
            r_idx  <= '0;
            r_cnt  <= '0;
            r_veri <= '0;
            r_hata <= 1'b0;
        end else begin
            case (r_durum)
                BOSTA: if (istek_i) begin
                    r_adr  <= adres_i[IC_ADRES_GENISLIGI-1:0];
                    r_dat  <= veri_i;
                    r_sel  <= sec_i;
                    r_yaz  <= yaz_i;
                    r_idx  <= w_idx;
                    r_cnt  <= '0;
                    r_veri <= '0;
                    r_hata <= ~w_any;
                end
                ACK_BEKLE: begin
                    r_cnt <= w_cnt_inc;
                    // Error has priority over a simultaneous ack.
                    if (w_err) begin
                        r_hata <= 1'b1;
                    end else if (w_ack) begin
                        r_hata <= 1'b0;
                        r_veri <= r_yaz ? '0 : w_rdat;
                    end else if (w_timeout) begin
                        r_hata <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign hazir_o   = (r_durum == YANIT);
    assign veri_o    = r_veri;
    assign hata_o    = r_hata;
    assign wbs_adr_o = r_adr;
    assign wbs_dat_o = r_dat;
    assign wbs_sel_o = r_sel;
    assign wbs_cyc_o = w_aktif;
    assign wbs_stb_o = w_aktif;
    assign wbs_we_o  = w_aktif & {SLAVE_SAYISI{r_yaz}};
endmodule

// File: tb/tb_vyd_wbm_kopru.sv
// Directed table-driven bench for vyd_wbm_kopru with a cycle-level slave responder.
module tb_vyd_wbm_kopru;
    localparam int N = 2;
    localparam int W = 32;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic [31:0]     adres_i;
    logic [W-1:0]    veri_i;
    logic [3:0]      sec_i;
    logic            yaz_i;
    logic            istek_i;
    logic            hazir_o;
    logic [W-1:0]    veri_o;
    logic            hata_o;
    logic [15:0]     wbs_adr_o;
    logic [W-1:0]    wbs_dat_o;
    logic [3:0]      wbs_sel_o;
    logic [N-1:0]    wbs_we_o;
    logic [N-1:0]    wbs_stb_o;
    logic [N-1:0]    wbs_cyc_o;
    logic [N*W-1:0]  wbs_dat_i;
    logic [N-1:0]    wbs_ack_i;
    logic [N-1:0]    wbs_err_i;

    int checks   = 0;
    int failures = 0;

    vyd_wbm_kopru #(
        .ADRES_GENISLIGI(32), .SOZCUK_GENISLIGI(32), .IC_ADRES_GENISLIGI(16), .SLAVE_SAYISI(2),
        .SLAVE_BASLANGIC('{32'h1000_0000, 32'h2000_0000}),
        .SLAVE_BITIS('{32'h1000_FFFF, 32'h2000_FFFF}),
        .ZAMAN_ASIMI(8)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .adres_i(adres_i), .veri_i(veri_i), .sec_i(sec_i),
        .yaz_i(yaz_i), .istek_i(istek_i), .hazir_o(hazir_o), .veri_o(veri_o), .hata_o(hata_o),
        .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o), .wbs_we_o(wbs_we_o),
        .wbs_stb_o(wbs_stb_o), .wbs_cyc_o(wbs_cyc_o), .wbs_dat_i(wbs_dat_i),
        .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i)
    );

    always #5 clk_i = ~clk_i;

    // resp: 0 none, 1 ack, 2 err, 3 ack+err; slv 2 means outside every window
    typedef struct {
        logic [31:0] adres; logic [31:0] veri; logic [3:0] sec; logic yaz;
        int slv; int resp; int wt; logic [31:0] rdat; logic stray;
        int exp_c; int exp_cyc; logic [31:0] exp_veri; logic exp_hata; logic chk_veri;
    } vek_t;

    vek_t vt [10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic idle_slaves();
        wbs_ack_i = '0;
        wbs_err_i = '0;
        wbs_dat_i = {32'hBAD0_0001, 32'hBAD0_0000};
    endtask

    task automatic run_vec(input vek_t v, input int id);
        int  got_c = -1;
        int  seen = 0, cyc_t = 0, cyc_o = 0, badbus = 0, other;
        logic [31:0] gv = '0;
        logic gh = 1'b0;
        bit done = 0;
        logic [N-1:0] exp_we;
        other  = (v.slv == 0) ? 1 : 0;
        exp_we = (v.slv < 2 && v.yaz) ? N'(1 << v.slv) : '0;
        @(negedge clk_i);
        adres_i = v.adres; veri_i = v.veri; sec_i = v.sec; yaz_i = v.yaz; istek_i = 1'b1;
        idle_slaves();
        for (int c = 1; c <= 40 && !done; c++) begin
            @(posedge clk_i);
            @(negedge clk_i);
            if (v.slv < 2) begin
                cyc_t += int'(wbs_cyc_o[v.slv]);
                cyc_o += int'(wbs_cyc_o[other]);
            end else begin
                cyc_o += int'(|wbs_cyc_o);
            end
            if (|wbs_cyc_o) begin
                if (wbs_adr_o !== v.adres[15:0] || wbs_dat_o !== v.veri || wbs_sel_o !== v.sec ||
                    wbs_we_o !== exp_we || wbs_stb_o !== wbs_cyc_o) badbus++;
            end
            idle_slaves();
            if (hazir_o) begin
                got_c = c; gv = veri_o; gh = hata_o; done = 1; istek_i = 1'b0;
            end else begin
                if (v.slv < 2 && wbs_cyc_o[v.slv]) begin
                    seen++;
                    if (seen == v.wt + 1 && v.resp != 0) begin
                        wbs_ack_i[v.slv] = v.resp[0];
                        wbs_err_i[v.slv] = v.resp[1];
                        wbs_dat_i[v.slv*W +: W] = v.rdat;
                    end
                end
                if (v.stray && v.slv < 2) wbs_ack_i[other] = 1'b1;
            end
        end
        @(posedge clk_i);
        @(negedge clk_i);
        chk($sformatf("v%0d_hazir_width", id), 64'(hazir_o), 64'(0));
        chk($sformatf("v%0d_hazir_cycle", id), 64'(got_c), 64'(v.exp_c));
        chk($sformatf("v%0d_hata", id), 64'(gh), 64'(v.exp_hata));
        if (v.chk_veri) chk($sformatf("v%0d_veri", id), 64'(gv), 64'(v.exp_veri));
        if (v.slv < 2) chk($sformatf("v%0d_cyc_target", id), 64'(cyc_t), 64'(v.exp_cyc));
        chk($sformatf("v%0d_cyc_other", id), 64'(cyc_o), 64'(0));
        chk($sformatf("v%0d_bus_fields", id), 64'(badbus), 64'(0));
        $display("txn %0d adres=%h yaz=%b hazir_cycle=%0d veri_o=%h hata_o=%b cyc=%0d",
                 id, v.adres, v.yaz, got_c, gv, gh, cyc_t);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        int late_hazir;
        vt[0] = '{32'h2000_0004, 32'h0,      4'hF, 1'b0, 1, 1, 3, 32'hDEADBEEF, 1'b0, 5, 4, 32'hDEADBEEF, 1'b0, 1'b1};
        vt[1] = '{32'h1000_0010, 32'h55,     4'h1, 1'b1, 0, 1, 0, 32'h0,        1'b0, 2, 1, 32'h0,        1'b0, 1'b0};
        vt[2] = '{32'h3000_0000, 32'h1234,   4'hF, 1'b0, 2, 0, 0, 32'h0,        1'b0, 1, 0, 32'h0,        1'b1, 1'b1};
        vt[3] = '{32'h1000_0020, 32'h0,      4'hF, 1'b0, 0, 0, 0, 32'h0,        1'b0, 9, 8, 32'h0,        1'b1, 1'b0};
        vt[4] = '{32'h2000_0010, 32'h0,      4'hF, 1'b0, 1, 3, 1, 32'h12345678, 1'b0, 3, 2, 32'h0,        1'b1, 1'b0};
        vt[5] = '{32'h1000_0030, 32'hA5A5,   4'h3, 1'b1, 0, 2, 2, 32'h0,        1'b0, 4, 3, 32'h0,        1'b1, 1'b0};
        vt[6] = '{32'h2000_0020, 32'h0,      4'hF, 1'b0, 1, 1, 1, 32'h87654321, 1'b1, 3, 2, 32'h87654321, 1'b0, 1'b1};
        vt[7] = '{32'h1000_FFFF, 32'h0,      4'hF, 1'b0, 0, 1, 0, 32'hCAFEF00D, 1'b0, 2, 1, 32'hCAFEF00D, 1'b0, 1'b1};
        vt[8] = '{32'h2000_0000, 32'h0,      4'hC, 1'b0, 1, 1, 0, 32'h13579BDF, 1'b0, 2, 1, 32'h13579BDF, 1'b0, 1'b1};
        vt[9] = '{32'h1001_0000, 32'h0,      4'hF, 1'b0, 2, 0, 0, 32'h0,        1'b0, 1, 0, 32'h0,        1'b1, 1'b1};

        rst_i = 1'b1; adres_i = '0; veri_i = '0; sec_i = '0; yaz_i = 1'b0; istek_i = 1'b0;
        idle_slaves();
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("reset_hazir", 64'(hazir_o), 64'(0));
        chk("reset_cyc", 64'(wbs_cyc_o), 64'(0));
        chk("reset_veri", 64'(veri_o), 64'(0));
        chk("reset_hata", 64'(hata_o), 64'(0));
        rst_i = 1'b0;

        for (int i = 0; i < 10; i++) run_vec(vt[i], i);

        // Reset in the middle of a wait: bus released, late ack must not complete anything.
        @(negedge clk_i);
        adres_i = 32'h2000_0008; yaz_i = 1'b0; sec_i = 4'hF; veri_i = '0; istek_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        chk("midrst_cyc_before", 64'(wbs_cyc_o), 64'(2'b10));
        istek_i = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        chk("midrst_cyc", 64'(wbs_cyc_o), 64'(0));
        chk("midrst_stb", 64'(wbs_stb_o), 64'(0));
        chk("midrst_hazir", 64'(hazir_o), 64'(0));
        chk("midrst_adr", 64'(wbs_adr_o), 64'(0));
        chk("midrst_hata", 64'(hata_o), 64'(0));
        rst_i = 1'b0;
        wbs_ack_i = 2'b10;
        wbs_dat_i[W +: W] = 32'hFEEDFACE;
        late_hazir = 0;
        repeat (3) begin
            @(posedge clk_i);
            @(negedge clk_i);
            late_hazir += int'(hazir_o) + int'(|wbs_cyc_o);
        end
        chk("midrst_late_ack", 64'(late_hazir), 64'(0));
        $display("txn reset-abort late_activity=%0d", late_hazir);
        idle_slaves();
        run_vec(vt[8], 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
